// File: rtl/fifo_wr_arbiter_if.sv
// ---------------------------------------------------------------------------
// fifo_wr_arbiter_if
// Bundles the requester-side handshake and the FIFO write-side signals of
// fifo_wr_arbiter.
//   master : arbiter view. It drives req_ready, the FIFO write port and the
//            grant/error status.
//   slave  : environment view. Producers and the FIFO drive req_* and the
//            FIFO flags.
// Signals
//   req_valid/req_last [N_REQ]   per-requester valid / last beat of burst
//   req_data [N_REQ*FIFO_WIDTH]  packed data, requester i at [i*W +: W]
//   req_ready [N_REQ]            beat accepted this cycle
//   fifo_wr_en, fifo_data_in     FIFO write port
//   fifo_full, fifo_overflow     FIFO flags
//   grant_valid, grant_id        current owner of the write port
//   err_overflow                 sticky overflow error
// ---------------------------------------------------------------------------
interface fifo_wr_arbiter_if #(
  parameter int N_REQ      = 4,
  parameter int FIFO_WIDTH = 16
);
  localparam int ID_W = $clog2(N_REQ);

  logic [N_REQ-1:0]            req_valid;
  logic [N_REQ-1:0]            req_last;
  logic [N_REQ*FIFO_WIDTH-1:0] req_data;
  logic [N_REQ-1:0]            req_ready;
  logic                        fifo_wr_en;
  logic [FIFO_WIDTH-1:0]       fifo_data_in;
  logic                        fifo_full;
  logic                        fifo_overflow;
  logic                        grant_valid;
  logic [ID_W-1:0]             grant_id;
  logic                        err_overflow;

  modport master (
    input  req_valid, req_last, req_data, fifo_full, fifo_overflow,
    output req_ready, fifo_wr_en, fifo_data_in, grant_valid, grant_id, err_overflow
  );

  modport slave (
    output req_valid, req_last, req_data, fifo_full, fifo_overflow,
    input  req_ready, fifo_wr_en, fifo_data_in, grant_valid, grant_id, err_overflow
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// ---------------------------------------------------------------------------
// fifo_wr_arbiter
// Shares the single write port of a synchronous FIFO between N_REQ
// requesters. Round-robin arbitration, rotating once per completed burst;
// a grant lasts at most BURST_MAX beats. fifo_full stalls the owner without
// ending its burst. fifo_overflow is latched into a sticky error.
// Ports
//   clk  : clock, all logic on posedge
//   rst  : synchronous active-high reset
//   bus  : fifo_wr_arbiter_if.master (requester handshake, FIFO write side,
//          grant status, err_overflow)
// fifo_wr_en, fifo_data_in and req_ready are combinational from the
// registered grant. grant_valid, grant_id and err_overflow are registers.
// ---------------------------------------------------------------------------
module fifo_wr_arbiter #(
  parameter int N_REQ      = 4,
  parameter int FIFO_WIDTH = 16,
  parameter int BURST_MAX  = 4
) (
  input logic                clk,
  input logic                rst,
  fifo_wr_arbiter_if.master  bus
);
  localparam int ID_W  = $clog2(N_REQ);
  localparam int CNT_W = $clog2(BURST_MAX) + 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_MAX - 1);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_e;

  state_e          state_r,       state_n;
  logic [ID_W-1:0] grant_id_r,    grant_id_n;
  logic            grant_valid_r, grant_valid_n;
  logic [ID_W-1:0] last_grant_r,  last_grant_n;
  logic [CNT_W-1:0] beat_cnt_r,   beat_cnt_n;
  logic            err_overflow_r;

  logic [N_REQ-1:0]      ready_s;
  logic                  wr_en_s;
  logic [FIFO_WIDTH-1:0] data_s;
  logic                  owner_valid_s;
  logic                  owner_last_s;
  logic [FIFO_WIDTH-1:0] owner_data_s;

  // First requester with valid set, searching upward from last+1 modulo N_REQ.
  function automatic logic [ID_W-1:0] rr_pick(input logic [N_REQ-1:0] valid,
                                               input logic [ID_W-1:0]  last);
    logic [ID_W-1:0] pick;
    logic            found;
    int              idx;
    pick  = '0;
    found = 1'b0;
    for (int i = 1; i <= N_REQ; i++) begin
      idx = (int'(last) + i) % N_REQ;
      if (!found && valid[idx]) begin
        pick  = ID_W'(idx);
        found = 1'b1;
      end else begin
        found = found;
      end
    end
    return pick;
  endfunction

  // Select the current owner's valid/last/data slice.
  always_comb begin
    owner_valid_s = 1'b0;
    owner_last_s  = 1'b0;
    owner_data_s  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant_id_r == ID_W'(i)) begin
        owner_valid_s = bus.req_valid[i];
        owner_last_s  = bus.req_last[i];
        owner_data_s  = bus.req_data[i*FIFO_WIDTH +: FIFO_WIDTH];
      end else begin
        owner_valid_s = owner_valid_s;
      end
    end
  end

  // Next-state logic and combinational write-port outputs.
  always_comb begin
    state_n       = state_r;
    grant_id_n    = grant_id_r;
    grant_valid_n = grant_valid_r;
    last_grant_n  = last_grant_r;
    beat_cnt_n    = beat_cnt_r;
    ready_s       = '0;
    wr_en_s       = 1'b0;
    data_s        = '0;

    case (state_r)
      ST_IDLE: begin
        if (|bus.req_valid) begin
          state_n       = ST_BURST;
          grant_id_n    = rr_pick(bus.req_valid, last_grant_r);
          grant_valid_n = 1'b1;
          beat_cnt_n    = '0;
        end else begin
          state_n = ST_IDLE;
        end
      end

      ST_BURST: begin
        // rst gating keeps the reset cycle free of writes and accepted beats.
        for (int i = 0; i < N_REQ; i++) begin
          if (grant_id_r == ID_W'(i)) begin
            ready_s[i] = !bus.fifo_full && !rst;
          end else begin
            ready_s[i] = 1'b0;
          end
        end
        wr_en_s = owner_valid_s && !bus.fifo_full && !rst;
        data_s  = owner_data_s;

        if (!owner_valid_s) begin
          // Owner dropped: close the burst without a write.
          state_n       = ST_IDLE;
          grant_valid_n = 1'b0;
          last_grant_n  = grant_id_r;
          beat_cnt_n    = '0;
        end else if (wr_en_s) begin
          if (owner_last_s || (beat_cnt_r == LAST_BEAT)) begin
            state_n       = ST_IDLE;
            grant_valid_n = 1'b0;
            last_grant_n  = grant_id_r;
            beat_cnt_n    = '0;
          end else begin
            beat_cnt_n = beat_cnt_r + CNT_W'(1);
          end
        end else begin
          // Stalled on fifo_full: grant and beat count hold.
          beat_cnt_n = beat_cnt_r;
        end
      end

      default: begin
        state_n       = ST_IDLE;
        grant_valid_n = 1'b0;
      end
    endcase
  end

  // Arbiter state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= ST_IDLE;
      grant_id_r    <= '0;
      grant_valid_r <= 1'b0;
      last_grant_r  <= ID_W'(N_REQ - 1);
      beat_cnt_r    <= '0;
    end else begin
      state_r       <= state_n;
      grant_id_r    <= grant_id_n;
      grant_valid_r <= grant_valid_n;
      last_grant_r  <= last_grant_n;
      beat_cnt_r    <= beat_cnt_n;
    end
  end

  // Sticky overflow error, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_overflow_r <= 1'b0;
    end else if (bus.fifo_overflow) begin
      err_overflow_r <= 1'b1;
    end else begin
      err_overflow_r <= err_overflow_r;
    end
  end

  assign bus.req_ready    = ready_s;
  assign bus.fifo_wr_en   = wr_en_s;
  assign bus.fifo_data_in = data_s;
  assign bus.grant_valid  = grant_valid_r;
  assign bus.grant_id     = grant_id_r;
  assign bus.err_overflow = err_overflow_r;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_fifo_wr_arbiter
// Directed bench for fifo_wr_arbiter (N_REQ=4, FIFO_WIDTH=16, BURST_MAX=4).
// Each directed cycle pushes the writes it expects into a scoreboard queue;
// a monitor pops and compares {grant_id, fifo_data_in} on every fifo_wr_en.
// ---------------------------------------------------------------------------
module tb_fifo_wr_arbiter;
  localparam int N  = 4;
  localparam int W  = 16;
  localparam int BM = 4;

  logic clk;
  logic rst;

  fifo_wr_arbiter_if #(.N_REQ(N), .FIFO_WIDTH(W)) bus ();

  fifo_wr_arbiter #(.N_REQ(N), .FIFO_WIDTH(W), .BURST_MAX(BM)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_vec = 0;
  int n_err = 0;
  logic [17:0] exp_q[$];
  logic [7:0]  seq [N];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: every FIFO write must match the next expected one.
  always @(negedge clk) begin
    if (bus.fifo_wr_en === 1'b1) begin
      check("wr_while_full", {31'd0, bus.fifo_full}, 32'd0);
      if (exp_q.size() == 0) begin
        check("unexpected_write", {14'd0, bus.grant_id, bus.fifo_data_in}, 32'hFFFF_FFFF);
      end else begin
        check("fifo_write", {14'd0, bus.grant_id, bus.fifo_data_in}, {14'd0, exp_q.pop_front()});
      end
    end
  end

  task automatic set_data(input int i);
    bus.req_data[i*W +: W] = {4'(i), 4'h0, seq[i]};
  endtask

  task automatic expect_wr(input logic [1:0] id, input logic [15:0] data);
    exp_q.push_back({id, data});
  endtask

  // One clock: check outputs at negedge, then advance requesters whose beat was taken.
  task automatic step(input logic exp_wr, input logic exp_gv, input logic [1:0] exp_gid,
                      input logic [3:0] exp_rdy, input logic auto_data);
    logic [3:0] acc;
    @(negedge clk);
    check("fifo_wr_en", {31'd0, bus.fifo_wr_en}, {31'd0, exp_wr});
    check("grant_valid", {31'd0, bus.grant_valid}, {31'd0, exp_gv});
    if (exp_gv) check("grant_id", {30'd0, bus.grant_id}, {30'd0, exp_gid});
    check("req_ready", {28'd0, bus.req_ready}, {28'd0, exp_rdy});
    acc = bus.req_ready & bus.req_valid & {4{~rst}};
    @(posedge clk);
    #1;
    if (auto_data) begin
      for (int i = 0; i < N; i++) begin
        if (acc[i]) begin
          seq[i] = seq[i] + 8'd1;
          set_data(i);
        end
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    int order[5];
    logic       wr;
    logic [1:0] gid;
    order = '{0, 1, 2, 3, 0};

    rst = 1'b1;
    bus.req_valid     = 4'b0000;
    bus.req_last      = 4'b0000;
    bus.req_data      = '0;
    bus.fifo_full     = 1'b0;
    bus.fifo_overflow = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state.
    @(negedge clk);
    check("rst_grant_valid", {31'd0, bus.grant_valid}, 32'd0);
    check("rst_grant_id", {30'd0, bus.grant_id}, 32'd0);
    check("rst_err_overflow", {31'd0, bus.err_overflow}, 32'd0);
    check("rst_wr_en", {31'd0, bus.fifo_wr_en}, 32'd0);
    @(posedge clk);
    #1;

    // Single requester, three beats A1..A3 with last on the third.
    bus.req_valid = 4'b0001;
    bus.req_data[15:0] = 16'h00A1;
    expect_wr(2'd0, 16'h00A1);
    expect_wr(2'd0, 16'h00A2);
    expect_wr(2'd0, 16'h00A3);
    step(1'b0, 1'b0, 2'd0, 4'b0000, 1'b0);
    step(1'b1, 1'b1, 2'd0, 4'b0001, 1'b0);
    bus.req_data[15:0] = 16'h00A2;
    step(1'b1, 1'b1, 2'd0, 4'b0001, 1'b0);
    bus.req_data[15:0] = 16'h00A3;
    bus.req_last = 4'b0001;
    step(1'b1, 1'b1, 2'd0, 4'b0001, 1'b0);
    bus.req_valid = 4'b0000;
    bus.req_last  = 4'b0000;
    step(1'b0, 1'b0, 2'd0, 4'b0000, 1'b0);

    // All four requesters, no last: bursts of 4 in order 0,1,2,3,0 with one bubble.
    do_reset();
    for (int i = 0; i < N; i++) begin
      seq[i] = 8'd0;
      set_data(i);
    end
    for (int k = 0; k < 5; k++) begin
      for (int b = 0; b < 4; b++) begin
        expect_wr(2'(order[k]), {4'(order[k]), 4'h0, 8'((k == 4 ? 4 : 0) + b)});
      end
    end
    bus.req_valid = 4'b1111;
    for (int c = 0; c < 25; c++) begin
      wr  = (c % 5) != 0;
      gid = wr ? 2'(order[(c - 1) / 5]) : 2'd0;
      step(wr, wr, gid, wr ? (4'b0001 << gid) : 4'b0000, 1'b1);
      if (c == 24) bus.req_valid = 4'b0000;
    end
    step(1'b0, 1'b0, 2'd0, 4'b0000, 1'b1);

    // Full for 5 cycles after two beats: stall, hold grant, resume at beat 3.
    for (int b = 4; b < 8; b++) expect_wr(2'd1, {4'd1, 4'h0, 8'(b)});
    bus.req_valid = 4'b0010;
    for (int c = 0; c < 11; c++) begin
      bus.fifo_full = (c >= 3) && (c <= 7);
      wr = (c == 1) || (c == 2) || (c == 8) || (c == 9);
      step(wr, (c >= 1) && (c <= 9), 2'd1, wr ? 4'b0010 : 4'b0000, 1'b1);
      if (c == 9) bus.req_valid = 4'b0000;
    end
    bus.fifo_full = 1'b0;

    // Owner 2 drops after one beat; 3 then wins over re-raised 2.
    expect_wr(2'd2, 16'h2004);
    expect_wr(2'd3, 16'h3004);
    expect_wr(2'd2, 16'h2005);
    bus.req_valid = 4'b1100;
    bus.req_last  = 4'b1000;
    step(1'b0, 1'b0, 2'd0, 4'b0000, 1'b1);
    step(1'b1, 1'b1, 2'd2, 4'b0100, 1'b1);
    bus.req_valid = 4'b1000;
    step(1'b0, 1'b1, 2'd2, 4'b0100, 1'b1);
    bus.req_valid = 4'b1100;
    bus.req_last  = 4'b1100;
    step(1'b0, 1'b0, 2'd0, 4'b0000, 1'b1);
    step(1'b1, 1'b1, 2'd3, 4'b1000, 1'b1);
    bus.req_valid = 4'b0100;
    step(1'b0, 1'b0, 2'd0, 4'b0000, 1'b1);
    step(1'b1, 1'b1, 2'd2, 4'b0100, 1'b1);
    bus.req_valid = 4'b0000;
    bus.req_last  = 4'b0000;
    step(1'b0, 1'b0, 2'd0, 4'b0000, 1'b1);

    // Reset mid-burst while 2 owns the port; then req0 beats req2.
    expect_wr(2'd2, 16'h2006);
    expect_wr(2'd0, 16'h0008);
    bus.req_valid = 4'b0100;
    step(1'b0, 1'b0, 2'd0, 4'b0000, 1'b1);
    step(1'b1, 1'b1, 2'd2, 4'b0100, 1'b1);
    rst = 1'b1;
    bus.req_valid = 4'b0101;
    step(1'b0, 1'b1, 2'd2, 4'b0000, 1'b1);
    rst = 1'b0;
    step(1'b0, 1'b0, 2'd0, 4'b0000, 1'b1);
    step(1'b1, 1'b1, 2'd0, 4'b0001, 1'b1);
    bus.req_valid = 4'b0000;
    step(1'b0, 1'b1, 2'd0, 4'b0001, 1'b1);
    step(1'b0, 1'b0, 2'd0, 4'b0000, 1'b1);

    // One-cycle overflow pulse: sticky for 100 cycles, cleared by reset.
    bus.fifo_overflow = 1'b1;
    step(1'b0, 1'b0, 2'd0, 4'b0000, 1'b1);
    bus.fifo_overflow = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      check("err_overflow_held", {31'd0, bus.err_overflow}, 32'd1);
      @(posedge clk);
      #1;
    end
    do_reset();
    @(negedge clk);
    check("err_overflow_cleared", {31'd0, bus.err_overflow}, 32'd0);

    check("scoreboard_drained", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
